// File: rtl/systolic_sequencer.sv
// Job controller for the 5x5 weight-stationary systolic array: buffers input
// vectors, clears the array, feeds them with diagonal skew and returns results.
module systolic_sequencer #(
  parameter int N          = 5,
  parameter int DW         = 8,
  parameter int OW         = 16,
  parameter int CAP_OFFSET = 5
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [N*DW-1:0] load_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N*DW-1:0] arr_data_in,
  output logic            arr_clear,
  input  logic [N*OW-1:0] arr_data_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N*OW-1:0] res_data
);

  localparam int K_LAST = CAP_OFFSET + 2*(N-1);
  localparam int KW     = $clog2(K_LAST + 1);
  localparam int LW     = $clog2(N + 1);
  localparam int RW     = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, OUT} state_t;

  state_t          state, state_next;
  logic [KW-1:0]   k;
  logic [LW-1:0]   load_cnt;
  logic [RW-1:0]   res_cnt;
  logic [N*DW-1:0] vbuf    [N];
  logic [N*OW-1:0] res_buf [N];
  logic [N*DW-1:0] feed;
  int              feed_k;
  logic            load_fire, res_fire, k_last, res_last;

  assign load_fire = (state == IDLE) && load_valid && load_ready;
  assign res_fire  = (state == OUT) && res_valid && res_ready;
  assign k_last    = (k == KW'(K_LAST));
  assign res_last  = (res_cnt == RW'(N-1));

  always_ff @(posedge clk) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && load_cnt == LW'(N)) state_next = CLR;
      CLR:     state_next = RUN;
      RUN:     if (k_last) state_next = OUT;
      OUT:     if (res_fire && res_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Feed word for the cycle that follows: row r carries vector (k - r),
  // registered one cycle ahead so the array sees it during cycle k.
  always_comb begin
    feed_k = (state == CLR) ? 0 : int'(k) + 1;
    feed   = '0;
    for (int t = 0; t < N; t++) begin
      for (int r = 0; r < N; r++) begin
        if (t + r == feed_k) feed[r*DW +: DW] = vbuf[t][r*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      load_cnt    <= '0;
      res_cnt     <= '0;
      k           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_valid   <= 1'b0;
      load_ready  <= 1'b1;
      arr_data_in <= '0;
      arr_clear   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          arr_clear   <= 1'b0;
          arr_data_in <= '0;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
          if (state_next == CLR) begin
            arr_clear  <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end else if (load_fire) begin
            load_cnt   <= load_cnt + LW'(1);
            load_ready <= ((load_cnt + LW'(1)) < LW'(N));
          end else begin
            load_ready <= (load_cnt < LW'(N));
          end
        end
        CLR: begin
          arr_clear   <= 1'b0;
          arr_data_in <= feed;
          k           <= '0;
        end
        RUN: begin
          if (k_last) begin
            arr_data_in <= '0;
            res_cnt     <= '0;
            res_valid   <= 1'b1;
          end else begin
            k           <= k + KW'(1);
            arr_data_in <= feed;
          end
        end
        OUT: begin
          if (res_fire) begin
            if (res_last) begin
              res_valid  <= 1'b0;
              done       <= 1'b1;
              load_cnt   <= '0;
              load_ready <= 1'b1;
              busy       <= 1'b0;
            end else begin
              res_cnt <= res_cnt + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data storage carries no reset; control state decides what is meaningful.
  always_ff @(posedge clk) begin
    if (load_fire) vbuf[load_cnt] <= load_data;
    if (state == RUN) begin
      for (int c = 0; c < N; c++) begin
        for (int t = 0; t < N; t++) begin
          if (CAP_OFFSET + c + t == int'(k))
            res_buf[t][c*OW +: OW] <= arr_data_out[c*OW +: OW];
        end
      end
    end
    if (state == RUN && k_last)             res_data <= res_buf[0];
    else if (res_fire && !res_last)         res_data <= res_buf[res_cnt + RW'(1)];
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: table-driven jobs, handshake corner
// sequences and randomized jobs against a behavioural array/result model.
module tb_systolic_sequencer;
  localparam int N   = 5;
  localparam int DW  = 8;
  localparam int OW  = 16;
  localparam int CAP = 5;
  localparam int KL  = CAP + 2*(N-1);

  logic            clk = 1'b0;
  logic            clear, load_valid, load_ready, start, busy, done;
  logic            arr_clear, res_valid, res_ready;
  logic [N*DW-1:0] load_data, arr_data_in;
  logic [N*OW-1:0] arr_data_out, res_data;

  int passed = 0;
  int total  = 0;
  int acnt   = 0;

  logic [N*DW-1:0] cur_x   [N];
  logic [N*OW-1:0] exp_res [N];

  typedef struct packed {
    logic [N-1:0][DW-1:0] val;
    logic [N-1:0][OW-1:0] exp;
    logic [3:0]           pat;
  } job_t;
  job_t jobs [4];

  systolic_sequencer #(.N(N), .DW(DW), .OW(OW), .CAP_OFFSET(CAP)) dut (
    .clk(clk), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .busy(busy), .done(done),
    .arr_data_in(arr_data_in), .arr_clear(arr_clear), .arr_data_out(arr_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Array stand-in: cycle counter restarts on arr_clear; column c presents the
  // weighted sum of vector t = cnt - CAP - c, else a marker value.
  always @(posedge clk) begin
    if (arr_clear)          acnt <= 0;
    else if (acnt < 10000)  acnt <= acnt + 1;
  end

  function automatic logic [OW-1:0] model_col(input int c, input int cnt);
    int t, s;
    t = cnt - CAP - c;
    if (t < 0 || t >= N) return 16'hDEAD;
    s = 0;
    for (int r = 0; r < N; r++) s += (r + 1) * int'(cur_x[t][r*DW +: DW]);
    return OW'(s);
  endfunction

  always_comb begin
    arr_data_out = '0;
    for (int c = 0; c < N; c++) arr_data_out[c*OW +: OW] = model_col(c, acnt);
  end

  function automatic logic [N*DW-1:0] exp_feed(input int k);
    logic [N*DW-1:0] f;
    f = '0;
    for (int r = 0; r < N; r++) begin
      if (k - r >= 0 && k - r < N) f[r*DW +: DW] = cur_x[k - r][r*DW +: DW];
    end
    return f;
  endfunction

  function automatic void calc_exp();
    int s;
    for (int t = 0; t < N; t++) begin
      s = 0;
      for (int r = 0; r < N; r++) s += (r + 1) * int'(cur_x[t][r*DW +: DW]);
      for (int c = 0; c < N; c++) exp_res[t][c*OW +: OW] = OW'(s);
    end
  endfunction

  function automatic void rand_x();
    for (int t = 0; t < N; t++)
      for (int r = 0; r < N; r++) cur_x[t][r*DW +: DW] = DW'($urandom_range(0, 255));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic load_vec(input logic [N*DW-1:0] v);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = v;
    while (!load_ready && n < 20) begin tick(); n++; end
    chk("load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int t = 0; t < N; t++) load_vec(cur_x[t]);
  endtask

  // Runs a loaded job and returns in the cycle carrying the done pulse.
  task automatic run_job(input logic [3:0] pat);
    int got, cyc;
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_arr_clear", arr_clear, 1);
    chk("clr_busy", busy, 1);
    chk("clr_load_ready", load_ready, 0);
    chk("clr_feed", arr_data_in, 0);
    tick();
    for (int k = 0; k <= KL; k++) begin
      chk($sformatf("feed_k%0d", k), arr_data_in, exp_feed(k));
      if (k == 0) chk("run_arr_clear", arr_clear, 0);
      tick();
    end
    got = 0; cyc = 0;
    while (got < N && cyc < 100) begin
      res_ready = pat[3 - (cyc % 4)];
      chk($sformatf("res_valid_%0d", got), res_valid, 1);
      chk($sformatf("res_data_%0d", got), res_data, exp_res[got]);
      chk("done_early", done, 0);
      if (res_ready) got++;
      tick(); cyc++;
    end
    res_ready = 1'b0;
    chk("result_count", got, N);
    chk("done_pulse", done, 1);
    chk("done_res_valid", res_valid, 0);
    chk("done_load_ready", load_ready, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    jobs[0].val = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    jobs[0].exp = {16'd75, 16'd60, 16'd45, 16'd30, 16'd15};
    jobs[0].pat = 4'b1111;
    jobs[1].val = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    jobs[1].exp = {16'd75, 16'd60, 16'd45, 16'd30, 16'd15};
    jobs[1].pat = 4'b1001;
    jobs[2].val = {8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    jobs[2].exp = {16'd30, 16'd30, 16'd30, 16'd30, 16'd30};
    jobs[2].pat = 4'b1011;
    jobs[3].val = {8'd255, 8'd0, 8'd7, 8'd128, 8'd9};
    jobs[3].exp = {16'd3825, 16'd0, 16'd105, 16'd1920, 16'd135};
    jobs[3].pat = 4'b0110;

    clear = 1'b0; load_valid = 1'b0; start = 1'b0; res_ready = 1'b0; load_data = '0;
    for (int t = 0; t < N; t++) cur_x[t] = '0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_arr_clear", arr_clear, 1);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_arr_data_in", arr_data_in, 0);
    clear = 1'b1;
    tick();
    chk("idle_arr_clear", arr_clear, 0);

    // Table-driven jobs
    for (int j = 0; j < 4; j++) begin
      for (int t = 0; t < N; t++) begin
        cur_x[t]   = {N{jobs[j].val[t]}};
        exp_res[t] = {N{jobs[j].exp[t]}};
      end
      load_all();
      run_job(jobs[j].pat);
      tick();
      chk("done_once", done, 0);
    end

    // Start after only three loads is ignored and not remembered
    rand_x(); calc_exp();
    for (int t = 0; t < 3; t++) load_vec(cur_x[t]);
    start = 1'b1; tick(); start = 1'b0;
    chk("early_start_busy", busy, 0);
    chk("early_start_arr_clear", arr_clear, 0);
    chk("early_start_load_ready", load_ready, 1);
    tick();
    chk("early_start_forgotten", busy, 0);
    for (int t = 3; t < N; t++) load_vec(cur_x[t]);

    // Sixth load is refused; buffer keeps the first five
    load_valid = 1'b1; load_data = ~cur_x[0];
    chk("full_load_ready", load_ready, 0);
    tick(); tick();
    chk("full_load_ready_held", load_ready, 0);
    load_valid = 1'b0;
    run_job(4'b1101);

    // Back-to-back: load in the done cycle
    chk("b2b_load_ready", load_ready, 1);
    for (int t = 0; t < N; t++) begin
      cur_x[t]   = {N{8'd2}};
      exp_res[t] = {N{16'd30}};
    end
    load_vec(cur_x[0]);
    chk("b2b_done_once", done, 0);
    for (int t = 1; t < N; t++) load_vec(cur_x[t]);
    run_job(4'b1111);
    tick();

    // Reset in the middle of RUN at k=7
    rand_x();
    load_all();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (7) tick();
    chk("midrun_busy", busy, 1);
    clear = 1'b0; tick(); clear = 1'b1;
    chk("midrun_rst_arr_clear", arr_clear, 1);
    chk("midrun_rst_load_ready", load_ready, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_res_valid", res_valid, 0);
    tick();
    chk("midrun_arr_clear_low", arr_clear, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("midrun_buffer_discarded", busy, 0);
    rand_x(); calc_exp();
    load_all();
    run_job(4'b1010);
    tick();

    // Randomized jobs
    for (int j = 0; j < 4; j++) begin
      rand_x(); calc_exp();
      load_all();
      run_job(4'($urandom_range(0, 15)) | 4'b0001);
      tick();
      chk("rand_done_once", done, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
